trng_ctrl: RTL and testbench

TRNG_CTRL -- requirements
Module: trng_ctrl

---
 rtl/trng_ctrl.sv | 179 +++++++++++++++++
 tb/tb_trng_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/trng_ctrl.sv
// trng_ctrl -- sequencer for an array of TRNG cells.
//
// Enables every cell, waits until all of them report ready, captures one
// bit per cell into a WIDTH-bit word and hands that word to a consumer with
// a VALID/TAKEN handshake. If the cells are not all ready within TIMEOUT
// cycles, the request is aborted and a sticky TIMEOUT_ERR flag is raised.
//
// Optional feature (macro TRNG_CTRL_HEALTH_EN): a repetition check that
// discards a captured word equal to the last delivered word and re-arms the
// cells. With the macro undefined, every capture is delivered.
//
// Parameters:
//   WIDTH    number of cells / output word width
//   TIMEOUT  WAIT cycles before abort (1..65535)
// Ports:
//   CLK, RST      clock, asynchronous active-high reset
//   REQ           level request, sampled in IDLE only
//   BIT_IN        one random bit per cell
//   BIT_READY     per-cell ready flags
//   CELL_EN       enable to all cells
//   CELL_ACK      one-cycle acknowledge / flush pulse to all cells
//   DATA, VALID   captured word and its valid flag
//   TAKEN         consumer acknowledge, honoured only while VALID=1
//   BUSY          high whenever the FSM is not in IDLE
//   TIMEOUT_ERR   last request aborted on timeout (sticky until next REQ)
module trng_ctrl #(
    parameter int WIDTH   = 16,
    parameter int TIMEOUT = 1023
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             REQ,
    input  logic [WIDTH-1:0] BIT_IN,
    input  logic [WIDTH-1:0] BIT_READY,
    output logic             CELL_EN,
    output logic             CELL_ACK,
    output logic [WIDTH-1:0] DATA,
    output logic             VALID,
    input  logic             TAKEN,
    output logic             BUSY,
    output logic             TIMEOUT_ERR
);

    localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_WAIT    = 3'd1;
    localparam logic [2:0] S_CAPTURE = 3'd2;
    localparam logic [2:0] S_HOLD    = 3'd3;
    localparam logic [2:0] S_ABORT   = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic             cell_en_q, cell_en_d;
    logic             ack_q, ack_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic             err_q, err_d;
`ifdef TRNG_CTRL_HEALTH_EN
    logic [WIDTH-1:0] last_q, last_d;
    logic             have_last_q, have_last_d;
`endif

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        cell_en_d = cell_en_q;
        ack_d     = 1'b0;
        data_d    = data_q;
        valid_d   = valid_q;
        err_d     = err_q;
`ifdef TRNG_CTRL_HEALTH_EN
        last_d      = last_q;
        have_last_d = have_last_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (REQ) begin
                    state_d   = S_WAIT;
                    timer_d   = '0;
                    err_d     = 1'b0;
                    cell_en_d = 1'b1;
                end
            end
            S_WAIT: begin
                // Ready is checked before the timeout so a capture on the
                // timeout cycle wins and raises no error.
                if (&BIT_READY) begin
                    state_d   = S_CAPTURE;
                    data_d    = BIT_IN;
                    cell_en_d = 1'b0;
                    ack_d     = 1'b1;
                end else if (timer_q == TMAX) begin
                    state_d   = S_ABORT;
                    cell_en_d = 1'b0;
                    ack_d     = 1'b1;
                    err_d     = 1'b1;
                end else begin
                    // Only reached below TMAX, so the timer never wraps.
                    timer_d = timer_q + TW'(1);
                end
            end
            S_CAPTURE: begin
`ifdef TRNG_CTRL_HEALTH_EN
                // A repeat of the last delivered word is discarded and the
                // cells are re-armed; the first word after reset always goes.
                if (have_last_q && (data_q == last_q)) begin
                    state_d   = S_WAIT;
                    timer_d   = '0;
                    cell_en_d = 1'b1;
                end else begin
                    state_d     = S_HOLD;
                    valid_d     = 1'b1;
                    last_d      = data_q;
                    have_last_d = 1'b1;
                end
`else
                state_d = S_HOLD;
                valid_d = 1'b1;
`endif
            end
            S_HOLD: begin
                if (TAKEN) begin
                    state_d = S_IDLE;
                    valid_d = 1'b0;
                end
            end
            S_ABORT: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d   = S_IDLE;
                cell_en_d = 1'b0;
                valid_d   = 1'b0;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= S_IDLE;
            timer_q   <= '0;
            cell_en_q <= 1'b0;
            ack_q     <= 1'b0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
`ifdef TRNG_CTRL_HEALTH_EN
            last_q      <= '0;
            have_last_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            cell_en_q <= cell_en_d;
            ack_q     <= ack_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
            err_q     <= err_d;
`ifdef TRNG_CTRL_HEALTH_EN
            last_q      <= last_d;
            have_last_q <= have_last_d;
`endif
        end
    end

    assign CELL_EN     = cell_en_q;
    assign CELL_ACK    = ack_q;
    assign DATA        = data_q;
    assign VALID       = valid_q;
    assign BUSY        = busy_q;
    assign TIMEOUT_ERR = err_q;

endmodule

// File: tb/tb_trng_ctrl.sv
// Testbench for trng_ctrl (WIDTH=16, TIMEOUT=8). Each request is described
// by the WAIT-cycle index at which all cells become ready; the expected
// outcome (delivery vs. abort, pulse positions, DATA) follows from that
// index compared against TIMEOUT.
module tb_trng_ctrl;

    localparam int W  = 16;
    localparam int TO = 8;

    logic         CLK = 1'b0;
    logic         RST = 1'b1;
    logic         REQ = 1'b0;
    logic [W-1:0] BIT_IN = '0;
    logic [W-1:0] BIT_READY = '0;
    logic         TAKEN = 1'b0;
    logic         CELL_EN, CELL_ACK, VALID, BUSY, TIMEOUT_ERR;
    logic [W-1:0] DATA;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state: last captured word (DATA), last delivered word.
    logic [W-1:0] exp_data = '0;
    logic [W-1:0] last_deliv = '0;
    bit           have_last = 1'b0;

    trng_ctrl #(.WIDTH(W), .TIMEOUT(TO)) dut (
        .CLK(CLK), .RST(RST), .REQ(REQ), .BIT_IN(BIT_IN),
        .BIT_READY(BIT_READY), .CELL_EN(CELL_EN), .CELL_ACK(CELL_ACK),
        .DATA(DATA), .VALID(VALID), .TAKEN(TAKEN), .BUSY(BUSY),
        .TIMEOUT_ERR(TIMEOUT_ERR)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag, input logic err);
        chk({tag, ".en"},   CELL_EN, 1'b0);
        chk({tag, ".ack"},  CELL_ACK, 1'b0);
        chk({tag, ".vld"},  VALID, 1'b0);
        chk({tag, ".busy"}, BUSY, 1'b0);
        chk({tag, ".err"},  TIMEOUT_ERR, err);
        chk({tag, ".data"}, DATA, exp_data);
    endtask

    function automatic logic [W-1:0] partial();
        logic [W-1:0] p;
        p = W'($urandom);
        p[$urandom_range(0, W-1)] = 1'b0;
        return p;
    endfunction

    // Issue one request from IDLE. All cells become ready on WAIT cycle d
    // (0-based) carrying word w; retry_w is the word offered if w is
    // rejected by the repetition check. hold = HOLD cycles before TAKEN.
    task automatic do_req(input string tag, input int d, input logic [W-1:0] w,
                          input logic [W-1:0] retry_w, input int hold);
        int k;
        bit done;
        bit full;
        logic [W-1:0] cur_w;
        cur_w = w;
        k = 0;
        done = 0;
        REQ = 1'b1;
        tick();
        REQ = 1'b0;
        while (!done) begin
            chk({tag, ".wait_en"},   CELL_EN, 1'b1);
            chk({tag, ".wait_ack"},  CELL_ACK, 1'b0);
            chk({tag, ".wait_busy"}, BUSY, 1'b1);
            chk({tag, ".wait_err"},  TIMEOUT_ERR, 1'b0);
            chk({tag, ".wait_vld"},  VALID, 1'b0);
            full = (k >= d);
            if (full) begin
                BIT_READY = '1;
                BIT_IN    = cur_w;
            end else begin
                BIT_READY = partial();
                BIT_IN    = W'($urandom);
            end
            tick();
            BIT_READY = '0;
            if (full) begin
                // Ready seen on this WAIT cycle: CAPTURE, then HOLD.
                chk({tag, ".cap_ack"}, CELL_ACK, 1'b1);
                chk({tag, ".cap_en"},  CELL_EN, 1'b0);
                chk({tag, ".cap_vld"}, VALID, 1'b0);
                exp_data = cur_w;
                tick();
`ifdef TRNG_CTRL_HEALTH_EN
                if (have_last && cur_w == last_deliv) begin
                    chk({tag, ".rej_vld"}, VALID, 1'b0);
                    chk({tag, ".rej_ack"}, CELL_ACK, 1'b0);
                    cur_w = retry_w;
                    k = 0;
                    d = 1;
                    continue;
                end
`endif
                have_last  = 1'b1;
                last_deliv = cur_w;
                chk({tag, ".hold_vld"}, VALID, 1'b1);
                chk({tag, ".hold_data"}, DATA, cur_w);
                chk({tag, ".hold_ack"}, CELL_ACK, 1'b0);
                for (int h = 0; h < hold; h++) begin
                    REQ = 1'($urandom);
                    tick();
                    chk({tag, ".held_vld"}, VALID, 1'b1);
                    chk({tag, ".held_data"}, DATA, cur_w);
                end
                REQ = 1'b0;
                TAKEN = 1'b1;
                tick();
                TAKEN = 1'b0;
                chk_idle({tag, ".taken"}, 1'b0);
                done = 1;
            end else if (k == TO) begin
                chk({tag, ".abort_ack"},  CELL_ACK, 1'b1);
                chk({tag, ".abort_en"},   CELL_EN, 1'b0);
                chk({tag, ".abort_err"},  TIMEOUT_ERR, 1'b1);
                chk({tag, ".abort_busy"}, BUSY, 1'b1);
                chk({tag, ".abort_data"}, DATA, exp_data);
                tick();
                chk_idle({tag, ".post_abort"}, 1'b1);
                done = 1;
            end
            k++;
        end
        retry_w = '0;
    endtask

    initial begin
        int d;
        logic [W-1:0] w, wn;
        // Reset state while RST is held.
        #2;
        chk_idle("reset", 1'b0);
        tick();
        RST = 1'b0;
        tick();
        chk_idle("post_reset", 1'b0);

        // TAKEN outside HOLD does nothing.
        TAKEN = 1'b1;
        tick();
        TAKEN = 1'b0;
        chk_idle("taken_idle", 1'b0);

        // Basic delivery: ready 5 cycles after the REQ pulse.
        do_req("basic", 4, 16'hA5C3, 16'h0000, 2);

        // Timeout with one cell never ready, then a fresh request clears it.
        do_req("timeout", 100, 16'h0000, 16'h0000, 0);
        do_req("after_to", 2, 16'h3C5A, 16'h0000, 1);

        // Ready exactly on the timeout cycle: capture wins.
        do_req("edge_to", TO, 16'h0F0F, 16'h0000, 0);

        // Randomized requests, both sides of the timeout.
        for (int i = 0; i < 12; i++) begin
            d = $urandom_range(0, TO + 3);
            w = W'($urandom);
            wn = ~w;
            do_req("rand", d, w, wn, $urandom_range(0, 3));
        end

        // Asynchronous reset in HOLD.
        REQ = 1'b1;
        tick();
        REQ = 1'b0;
        BIT_READY = '1;
        BIT_IN = 16'hBEEF;
        tick();
        BIT_READY = '0;
        tick();
        chk("pre_rst_vld", VALID, 1'b1);
        #2;
        RST = 1'b1;
        #1;
        exp_data = '0;
        have_last = 1'b0;
        chk_idle("async_rst", 1'b0);
        tick();
        RST = 1'b0;
        do_req("post_rst_req", 3, 16'h5AA5, 16'h0000, 0);

        // REQ and TAKEN held high with cells always ready: back-to-back words.
        REQ = 1'b1;
        TAKEN = 1'b1;
        BIT_READY = '1;
        for (int i = 0; i < 3; i++) begin
            w = W'($urandom) | 16'h0001;
            w[15:8] = 8'(i);
            BIT_IN = w;
            tick();
            chk("b2b_wait_en", CELL_EN, 1'b1);
            chk("b2b_wait_ack", CELL_ACK, 1'b0);
            tick();
            chk("b2b_cap_ack", CELL_ACK, 1'b1);
            chk("b2b_cap_vld", VALID, 1'b0);
            BIT_IN = ~w;
            tick();
            chk("b2b_hold_vld", VALID, 1'b1);
            chk("b2b_hold_data", DATA, w);
            chk("b2b_hold_ack", CELL_ACK, 1'b0);
            exp_data = w;
            tick();
            chk("b2b_idle_vld", VALID, 1'b0);
            chk("b2b_idle_busy", BUSY, 1'b0);
        end
        REQ = 1'b0;
        TAKEN = 1'b0;
        BIT_READY = '0;
        have_last = 1'b1;
        last_deliv = exp_data;
        tick();
        chk_idle("b2b_end", 1'b0);

`ifdef TRNG_CTRL_HEALTH_EN
        // Repeated word discarded and re-armed; a fresh word is delivered.
        do_req("hlth1", 1, 16'h1234, 16'h0000, 0);
        do_req("hlth2", 1, 16'h1234, 16'h4321, 0);
        chk("hlth_last", last_deliv, 16'h4321);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
